// File: rtl/cn_flop_driver.sv
// cn_flop_driver
//   Drives the c/n inputs of an external CN flip-flop so that it steps through
//   a parallel target pattern, one bit per clock (bit 0 first). The flop has
//   no reset, so every run begins with one force-clear cycle (c=0, n=1). A
//   model of the flop state is kept in q_model. Optionally, the flop's q is
//   fed back and checked against that model.
//
//   CN flop law : next = q ? ~n : (n & c)
//   Excitation  : c = t & ~q, n = t ^ q   (target t, current state q)
//
// Parameters
//   LEN        pattern length in bits (>= 2)
// Ports
//   clk        rising-edge clock
//   reset      synchronous active-high reset
//   start      play request, sampled only in IDLE
//   stop       ends a looping run after the current bit (RUN only)
//   loop       latched at start; 1 = replay the pattern continuously
//   pattern    target sequence, latched at start
//   c, n       registered CN excitation
//   q_fb       external flop q (used only with the check feature)
//   q_model    modelled flop state
//   busy       high in INIT/RUN
//   done       one-cycle pulse at the end of a run
//   err        sticky model/feedback mismatch flag (check feature)
//   err_step   step index of the first mismatch (check feature)
// Build option
//   CN_DRV_CHECK_EN  defined: q_fb compare, err and err_step are live.
//                    undefined: err/err_step tied to 0, q_fb unused.

module cn_flop_driver #(
  parameter int LEN = 8
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      start,
  input  logic                      stop,
  input  logic                      loop,
  input  logic [LEN-1:0]            pattern,
  output logic                      c,
  output logic                      n,
  input  logic                      q_fb,
  output logic                      q_model,
  output logic                      busy,
  output logic                      done,
  output logic                      err,
  output logic [$clog2(LEN+2)-1:0]  err_step
);

  // idx doubles as the check step number, which reaches LEN in DONE.
  localparam int SW = $clog2(LEN + 2);
  localparam logic [SW-1:0] LAST = SW'(LEN - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_INIT,
    S_RUN,
    S_DONE
  } state_t;

  state_t          state_q, state_d;
  logic [LEN-1:0]  pat_q,   pat_d;
  logic            loop_q,  loop_d;
  logic [SW-1:0]   idx_q,   idx_d;
  logic            c_q,     c_d;
  logic            n_q,     n_d;
  logic            qm_q,    qm_d;
  logic            chk_q,   chk_d;
  logic            clr;

  logic [SW-1:0]   idx_nxt;
  logic [LEN-1:0]  pat_cur;
  logic [LEN-1:0]  pat_nxt;
  logic            cur_t;
  logic            nxt_t;

  // Current target bit and the bit that follows it (wrapping to bit 0).
  always_comb begin
    pat_cur = pat_q >> idx_q;
    cur_t   = pat_cur[0];
    idx_nxt = (idx_q == LAST) ? '0 : idx_q + SW'(1);
    pat_nxt = pat_q >> idx_nxt;
    nxt_t   = pat_nxt[0];
  end

  always_comb begin
    state_d = state_q;
    pat_d   = pat_q;
    loop_d  = loop_q;
    idx_d   = idx_q;
    qm_d    = qm_q;
    chk_d   = chk_q;
    c_d     = 1'b0;
    n_d     = 1'b0;
    clr     = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          pat_d   = pattern;
          loop_d  = loop;
          idx_d   = '0;
          chk_d   = 1'b0;
          clr     = 1'b1;
          n_d     = 1'b1;          // force-clear: next = 0 from either state
          state_d = S_INIT;
        end
      end
      S_INIT: begin
        qm_d    = 1'b0;
        chk_d   = 1'b1;
        idx_d   = '0;
        // Excitation for bit 0 from q=0 reduces to c = n = t.
        c_d     = pat_q[0];
        n_d     = pat_q[0];
        state_d = S_RUN;
      end
      S_RUN: begin
        qm_d = cur_t;
        if (stop || ((idx_q == LAST) && !loop_q)) begin
          // Step past the last bit so the DONE-cycle check reports its index.
          idx_d   = idx_q + SW'(1);
          state_d = S_DONE;
        end else begin
          idx_d = idx_nxt;
          c_d   = nxt_t & ~cur_t;
          n_d   = nxt_t ^ cur_t;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      pat_q   <= '0;
      loop_q  <= 1'b0;
      idx_q   <= '0;
      c_q     <= 1'b0;
      n_q     <= 1'b0;
      qm_q    <= 1'b0;
      chk_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pat_q   <= pat_d;
      loop_q  <= loop_d;
      idx_q   <= idx_d;
      c_q     <= c_d;
      n_q     <= n_d;
      qm_q    <= qm_d;
      chk_q   <= chk_d;
    end
  end

  assign c       = c_q;
  assign n       = n_q;
  assign q_model = qm_q;
  assign busy    = (state_q == S_INIT) || (state_q == S_RUN);
  assign done    = (state_q == S_DONE);

`ifdef CN_DRV_CHECK_EN
  logic          err_q;
  logic [SW-1:0] err_step_q;
  logic          mismatch;

  // q_model already reflects the flop's expected value at this edge.
  assign mismatch = chk_q && (busy || done) && (q_fb != qm_q);

  always_ff @(posedge clk) begin
    if (reset) begin
      err_q      <= 1'b0;
      err_step_q <= '0;
    end else if (clr) begin
      err_q      <= 1'b0;
      err_step_q <= '0;
    end else if (mismatch && !err_q) begin
      err_q      <= 1'b1;
      err_step_q <= idx_q;
    end
  end

  assign err      = err_q;
  assign err_step = err_step_q;
`else
  logic unused_chk;
  assign unused_chk = q_fb ^ chk_q ^ clr;
  assign err        = 1'b0;
  assign err_step   = '0;
`endif

endmodule

// File: tb/tb_cn_flop_driver.sv
// tb_cn_flop_driver
//   Directed bench for cn_flop_driver (LEN=8). A behavioural CN flop that
//   powers up at 1 is driven by the DUT's c/n; its q is fed back through
//   q_fb, with an override used to plant a single-step mismatch.

module tb_cn_flop_driver;

  localparam int LEN = 8;

`ifdef CN_DRV_CHECK_EN
  localparam bit CHK = 1'b1;
`else
  localparam bit CHK = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic       stop;
  logic       loop;
  logic [7:0] pattern;
  logic       c;
  logic       n;
  logic       q_fb;
  logic       q_model;
  logic       busy;
  logic       done;
  logic       err;
  logic [3:0] err_step;

  logic       flop      = 1'b1;
  logic       flop_live = 1'b0;
  logic       force_fb  = 1'b0;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  // External CN flop: next = q ? ~n : (n & c)
  always @(posedge clk) begin
    if (flop_live) flop <= flop ? ~n : (n & c);
  end

  assign q_fb = flop | force_fb;

  cn_flop_driver #(.LEN(LEN)) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .stop     (stop),
    .loop     (loop),
    .pattern  (pattern),
    .c        (c),
    .n        (n),
    .q_fb     (q_fb),
    .q_model  (q_model),
    .busy     (busy),
    .done     (done),
    .err      (err),
    .err_step (err_step)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Plays one run. nbits bits are expected to be played; in loop mode stop
  // is raised during the last of them. start_at re-asserts start during that
  // RUN bit; force_at forces q_fb=1 during the cycle checked as that step.
  // tab, when used, holds the expected {c,n} pairs, bit 0's pair in [15:14].
  task automatic run_seq(input logic [7:0] pat, input logic lp, input int nbits,
                         input int start_at, input int force_at,
                         input logic use_tab, input logic [15:0] tab);
    logic prev;
    logic t;
    logic ec;
    logic en;
    int   err_from;
    err_from = (CHK && force_at >= 0) ? force_at + 1 : 1000;

    @(negedge clk);
    start   = 1'b1;
    pattern = pat;
    loop    = lp;
    stop    = 1'b0;
    @(negedge clk);                       // after E0: INIT cycle
    start   = 1'b0;
    pattern = ~pat;                       // must have been latched
    loop    = ~lp;
    chk("init c", c, 0);
    chk("init n", n, 1);
    chk("init busy", busy, 1);
    chk("init done", done, 0);
    chk("init err", err, 0);
    chk("init err_step", err_step, 0);

    prev = 1'b0;                          // INIT result
    for (int j = 0; j < nbits; j++) begin
      @(negedge clk);                     // after E(j+1): bit j excitation visible
      force_fb = (j == force_at);
      stop     = lp && (j == nbits - 1);
      start    = (j == start_at);
      t = pat[j % LEN];
      if (use_tab) begin
        ec = tab[15 - 2*j];
        en = tab[14 - 2*j];
      end else begin
        ec = t & ~prev;
        en = t ^ prev;
      end
      chk($sformatf("flop j%0d", j), flop, prev);
      chk($sformatf("q_model j%0d", j), q_model, prev);
      chk($sformatf("c j%0d", j), c, ec);
      chk($sformatf("n j%0d", j), n, en);
      chk($sformatf("busy j%0d", j), busy, 1);
      chk($sformatf("done j%0d", j), done, 0);
      chk($sformatf("err j%0d", j), err, (j >= err_from) ? 1 : 0);
      chk($sformatf("err_step j%0d", j), err_step, (j >= err_from) ? force_at : 0);
      prev = t;
    end

    @(negedge clk);                       // DONE cycle
    force_fb = 1'b0;
    stop     = 1'b0;
    start    = 1'b0;
    loop     = 1'b0;
    pattern  = '0;
    chk("done pulse", done, 1);
    chk("done busy", busy, 0);
    chk("done c", c, 0);
    chk("done n", n, 0);
    chk("done flop", flop, prev);
    chk("done q_model", q_model, prev);
    chk("done err", err, (nbits >= err_from) ? 1 : 0);
    chk("done err_step", err_step, (nbits >= err_from) ? force_at : 0);

    @(negedge clk);                       // back in IDLE
    chk("idle done", done, 0);
    chk("idle busy", busy, 0);
    chk("idle flop", flop, prev);
    chk("idle err", err, (nbits >= err_from) ? 1 : 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    reset   = 1'b1;
    start   = 1'b0;
    stop    = 1'b0;
    loop    = 1'b0;
    pattern = '0;
    repeat (2) @(negedge clk);
    chk("rst c", c, 0);
    chk("rst n", n, 0);
    chk("rst q_model", q_model, 0);
    chk("rst busy", busy, 0);
    chk("rst done", done, 0);
    chk("rst err", err, 0);
    chk("rst err_step", err_step, 0);
    reset     = 1'b0;
    flop_live = 1'b1;
    @(negedge clk);
    chk("powerup flop", flop, 1);

    // Basic run: flop reads 0, then 0,1,0,0,1,1,0,1
    run_seq(8'b1011_0010, 1'b0, 8, -1, -1, 1'b0, 16'h0);

    // All four (q,t) pairs: set/clear/hold codes from a hand table
    run_seq(8'b0011_0101, 1'b0, 8, -1, -1, 1'b1, 16'hDDC4);

    // Loop run, stop during idx 3 of pass 2: 12 bits, flop ends at 0
    run_seq(8'hA5, 1'b1, 12, -1, -1, 1'b0, 16'h0);

    // Reset in the middle of RUN (during idx 4)
    @(negedge clk);
    start   = 1'b1;
    pattern = 8'b1011_0010;
    loop    = 1'b0;
    repeat (6) begin
      @(negedge clk);
      start = 1'b0;
    end
    reset = 1'b1;
    @(negedge clk);
    chk("midrst c", c, 0);
    chk("midrst n", n, 0);
    chk("midrst busy", busy, 0);
    chk("midrst done", done, 0);
    chk("midrst q_model", q_model, 0);
    chk("midrst flop", flop, 1);          // bit 4 landed on the same edge
    reset = 1'b0;
    @(negedge clk);
    chk("postrst done", done, 0);
    chk("postrst busy", busy, 0);
    run_seq(8'b1011_0010, 1'b0, 8, -1, -1, 1'b0, 16'h0);

    // q_fb forced high at step 3 (model value pattern[2]=0)
    run_seq(8'b1011_0010, 1'b0, 8, -1, 3, 1'b0, 16'h0);

    // Next start clears err; start raised during RUN must be ignored
    run_seq(8'b0011_0101, 1'b0, 8, 2, -1, 1'b1, 16'hDDC4);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
